cpu_out_capture: RTL
====================

# cpu_out_capture

Captures the values a running CPU writes to its output port (`OutReg`) and delivers them, in order, to a downstream consumer over a valid/accept handshake. It sits between the CPU's output port and any sink: a display driver, a UART transmitter, or a checker in a bench. It also watches `Ready`/`Halt` so the consumer learns when the program has finished and every captured value has been drained.

## Interface
- `DataWidth`, 16: width of `OutReg` and `Data`.
- `Depth`, 8: FIFO entries; must be a power of two, ≥ 2.
- `PtrWidth`, 3: log2(`Depth`).
- `Clk` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-high; clears all state immediately.
- `CPU_Ready` in 1: CPU has left reset and is executing.
- `CPU_Halt` in 1: CPU has executed HALT.
- `OutReg` in `DataWidth`: CPU output port value.
- `Data` out `DataWidth`: head-of-FIFO value; forced to 0 while `Valid`=0.
- `Valid` out 1: FIFO not empty.
- `Accept` in 1: consumer takes `Data` on an edge where `Valid`=1.
- `Count` out `PtrWidth+1`: FIFO occupancy, 0..`Depth`.
- `Overflow` out 1: sticky; a capture was dropped because the FIFO was full.
- `Done` out 1: halt seen and FIFO fully drained.

## Operation
- States: `S_Idle`, `S_Capture`, `S_Drain`, `S_Done`.
- Shadow register `prev` (`DataWidth`) holds the last sampled `OutReg`.
- `S_Idle`: no captures. When `CPU_Ready`=1, load `prev` ← `OutReg` (baseline, not pushed) and go to `S_Capture`.
- `S_Capture`: each edge, push `OutReg` when `OutReg` ≠ `prev`; `prev` ← `OutReg` every edge. If `CPU_Halt`=1, still evaluate the push on that edge, then go to `S_Drain`.
- `S_Drain`: no pushes. Go to `S_Done` on the first edge where the FIFO is empty after any pop on that edge (occupancy 0, or 1 with a pop).
- `S_Done`: `Done`=1. Stay here until `CPU_Ready`=0.
- `CPU_Ready`=0 in any non-Idle state returns to `S_Idle` on the next edge. This has priority over all other transitions. FIFO contents and `Overflow` are kept; only `Reset` clears them.
- Pop: on an edge with `Valid`=1 and `Accept`=1. `Accept` while empty is ignored.
- Push while full: dropped and `Overflow` ← 1, unless a pop happens on the same edge; then the push is accepted and `Count` is unchanged.
- Push and pop on the same edge with `Count`≥1: both happen and `Count` is unchanged.
- Push while empty: no fall-through. Data appears on the next edge.
- Pointers are `PtrWidth` bits, wrap modulo `Depth`. `Count` is tracked separately (or via an extra pointer bit).

## Timing
- Reset values: state `S_Idle`, `Valid`=0, `Data`=0, `Count`=0, `Overflow`=0, `Done`=0, pointers 0, `prev`=0.
- Capture latency: an `OutReg` change present at edge N sets `Valid`=1 and `Data`=value after edge N. That is one cycle.
- `Data`, `Valid`, `Count`, `Done` derive from registered state only. `Data` may be a combinational read of the registered FIFO array.
- Throughput: one push and one pop per cycle.
- `Done` rises after the edge that empties the FIFO in `S_Drain`. If the FIFO is already empty, it rises two edges after `CPU_Halt` is seen (Capture→Drain, Drain→Done).
- A value that changes and reverts between edges is never seen; sampling is per edge only.
- `Reset` mid-operation: outputs reach their reset values without waiting for a clock edge. Captured data is lost.

## Test plan
- Reset, then `CPU_Ready`=1 with `OutReg`=0x0000, then `OutReg` = 0x0001, 0x0002, 0x0003 on successive edges with `Accept`=1 → `Data` sequence 0x0001, 0x0002, 0x0003, each one cycle after its edge. Baseline 0x0000 is not delivered.
- `OutReg` held at 0x00AA for 10 cycles after one change → exactly one entry; `Count` peaks at 1.
- `Accept`=0, 9 distinct changes with `Depth`=8 → `Count`=8, `Overflow`=1, 9th value dropped. Then drain → first 8 values in order; `Overflow` stays 1.
- Full FIFO, push and pop on the same edge → `Count` stays 8, new value accepted, `Overflow` stays 0.
- 3 entries pending, `CPU_Halt`=1 with a simultaneous change to 0x0042 → 0x0042 captured. `Done` stays 0 through 4 pops and rises after the last one. A later `OutReg` change is ignored; `CPU_Ready`=0 → `S_Idle`, `Done`=0.
- Assert `Reset` asynchronously mid-burst with `Count`=5 → `Valid`, `Count`, `Overflow`, `Done` go to 0 before the next `Clk` edge.

Source files
------------

// File: rtl/cpu_out_capture_if.sv
// Handshake bundle between the CPU output port, the capture block and its downstream consumer.
`timescale 1ns/1ps
interface cpu_out_capture_if #(
    parameter int DataWidth = 16,
    parameter int PtrWidth  = 3
);
    logic                 cpu_ready;
    logic                 cpu_halt;
    logic [DataWidth-1:0] out_reg;
    logic [DataWidth-1:0] data;
    logic                 valid;
    logic                 accept;
    logic [PtrWidth:0]    count;
    logic                 overflow;
    logic                 done;

    modport master (
        output cpu_ready, cpu_halt, out_reg, accept,
        input  data, valid, count, overflow, done
    );

    modport slave (
        input  cpu_ready, cpu_halt, out_reg, accept,
        output data, valid, count, overflow, done
    );
endinterface

// File: rtl/cpu_out_capture.sv
// Records each change of the CPU output port into a FIFO and hands the values to a consumer
// over valid/accept, signalling done once the CPU has halted and the FIFO is drained.
`timescale 1ns/1ps
module cpu_out_capture #(
    parameter int DataWidth = 16,
    parameter int Depth     = 8,
    parameter int PtrWidth  = 3
) (
    input  logic              clk,
    input  logic              rst,
    cpu_out_capture_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    localparam logic [PtrWidth:0] FullCount = (PtrWidth + 1)'(Depth);

    state_t               state;
    state_t               state_next;
    logic [DataWidth-1:0] mem [Depth];
    logic [PtrWidth-1:0]  wr_ptr;
    logic [PtrWidth-1:0]  rd_ptr;
    logic [PtrWidth:0]    count;
    logic [DataWidth-1:0] prev;
    logic                 overflow;
    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 push_req;
    logic                 push;
    logic                 drop;

    assign empty    = (count == '0);
    assign full     = (count == FullCount);
    assign pop      = !empty && bus.accept;
    assign push_req = (state == S_CAPTURE) && (bus.out_reg != prev);
    // A pop on the same edge frees the slot, so a full FIFO can still take the new value.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (bus.cpu_ready) begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!bus.cpu_ready) begin
                    state_next = S_IDLE;
                end else if (bus.cpu_halt) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!bus.cpu_ready) begin
                    state_next = S_IDLE;
                end else if (empty || (count == (PtrWidth + 1)'(1) && pop)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.cpu_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The first sample after the CPU comes up is only a baseline for change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
        end else if ((state == S_IDLE && bus.cpu_ready) || state == S_CAPTURE) begin
            prev <= bus.out_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.out_reg;
        end
    end

    assign bus.valid    = !empty;
    assign bus.data     = empty ? '0 : mem[rd_ptr];
    assign bus.count    = count;
    assign bus.overflow = overflow;
    assign bus.done     = (state == S_DONE);
endmodule
